preset_wave_ctrl: RTL and testbench
===================================

# preset_wave_ctrl

Front-panel preset controller for the TX path, driving the DDS frequency word and the one-hot-low waveform select. Two raw push-buttons are synchronised and debounced on `clk`. They step through a parametrised preset table, whose last slot tracks the SPI-written settings, and rotate a waveform override. An SPI-enabled linear frequency sweep runs inside the SPI slot. All key handling is synchronous to `clk`; there is no key-edge clocking.

## Interface
- NUM_PRESET, 4, preset slots including the SPI slot; minimum 2
- FW, 32, frequency word width
- NUM_WAVE, 3, waveform count; `sel_wave` width
- BASE_FREQ, 34300, fixed preset `i` frequency is BASE_FREQ*(i+3)
- DB_CYCLES, 1000000, stable-level cycles for key acceptance (20 ms @ 50 MHz)
- SWEEP_DWELL, 50000, cycles per sweep step
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_mode_n  in  1  raw preset key, active-low, asynchronous
- key_wave_n  in  1  raw wave key, active-low, asynchronous
- spi_fre  in  FW  SPI slot frequency / sweep start
- spi_wave  in  WW=$clog2(NUM_WAVE)  SPI slot wave index
- sweep_en  in  1  enables sweep while in SPI slot
- sweep_stop  in  FW  sweep upper bound (inclusive)
- sweep_step  in  FW  sweep increment
- fre_k  out  FW  registered frequency word
- sel_wave  out  NUM_WAVE  registered one-hot-low wave select
- preset_idx  out  $clog2(NUM_PRESET)  current slot
- sweeping  out  1  high while in ST_SWEEP
- fre_valid  out  1  one-cycle pulse whenever `fre_k` or `sel_wave` changes value

## Operation
- Keys: 2-FF synchroniser, then a counter. A new level is accepted after DB_CYCLES consecutive identical samples. An accepted 1→0 transition gives a one-cycle `press` pulse; release produces nothing.
- mode press: `preset_idx` increments, wrapping NUM_PRESET-1→0; `wave_ofs` clears to 0.
- wave press: `wave_ofs` = (`wave_ofs`+1) mod NUM_WAVE.
- Simultaneous presses: the preset advances and `wave_ofs` becomes 1.
- Fixed slot i < NUM_PRESET-1: freq = BASE_FREQ*(i+3); base wave = i mod NUM_WAVE.
- SPI slot: base wave = `spi_wave`, or 0 if `spi_wave` ≥ NUM_WAVE.
- Effective wave w = (base+`wave_ofs`) mod NUM_WAVE. `sel_wave` has all bits 1 except bit w = 0.
- FSM:
  - ST_FIXED: `preset_idx` < NUM_PRESET-1.
  - ST_TRACK: SPI slot with `sweep_en`=0; `fre_k` follows `spi_fre` every cycle.
  - ST_SWEEP: SPI slot with `sweep_en`=1.
  - Transitions are evaluated every cycle from `preset_idx` and `sweep_en`.
- ST_SWEEP entry: the sweep accumulator loads `spi_fre` and the dwell counter clears.
- Each SWEEP_DWELL cycles, next = acc + `sweep_step`, computed FW+1 wide.
  - Carry out, or next > `sweep_stop`: reload `spi_fre` (wrap).
  - `sweep_step`=0, or `spi_fre` > `sweep_stop`: hold at `spi_fre`.
- Leaving ST_SWEEP (key press or `sweep_en` falls): the sweep aborts immediately, with no completion of the current dwell.

## Timing
- Reset values:
  - `preset_idx`=0, `wave_ofs`=0, state ST_FIXED.
  - `fre_k`=BASE_FREQ*3.
  - `sel_wave`= all ones with bit 0 low (3'b110 at default).
  - `sweeping`=0, `fre_valid`=0.
  - Debounce levels = 1 (released).
- Key latency: the raw edge propagates through 2 sync cycles plus DB_CYCLES before the `press` pulse.
- `press` at cycle t:
  - `preset_idx`/`wave_ofs` update at t+1.
  - `fre_k`/`sel_wave`/`sweeping` update at t+2.
  - `fre_valid` pulses at t+2 only if a value changed.
- ST_TRACK: a `spi_fre` change at t appears on `fre_k` at t+1.
- ST_SWEEP: `fre_k` steps exactly every SWEEP_DWELL cycles; the first step comes SWEEP_DWELL cycles after entry.
- Reset mid-sweep or mid-debounce: everything returns to reset values on assertion; no press is generated on deassertion.

## Structure
- Shared package `tx_ctrl_pkg`: FSM state enum (ST_FIXED, ST_TRACK, ST_SWEEP) and default BASE_FREQ / DB_CYCLES constants.
- One sub-module, `key_debounce` (params DB_CYCLES; ports clk, rst, kin_n, level, press), instantiated twice.
- The preset table is computed combinationally from `preset_idx`; no ROM.

## Test plan
- Reset with defaults → `fre_k`=102900, `sel_wave`=3'b110, `preset_idx`=0, `fre_valid`=0.
- Key bounce of 10 toggles <DB_CYCLES apart, then stable low (DB_CYCLES=16 in bench) → exactly one press; `preset_idx`=1, `fre_k`=137200, `sel_wave`=3'b101 at press+2.
- Four mode presses from reset → wraps to idx 0. At idx 3 with `spi_fre`=5000, `spi_wave`=2 → `fre_k`=5000, `sel_wave`=3'b011; a `spi_fre` change tracks in 1 cycle; `spi_wave`=3 → 3'b110.
- Wave press twice at idx 0, then mode press in the same cycle as a wave press → `wave_ofs` 2 then 1; `sel_wave` 3'b011 then (idx 1, w=2) 3'b011.
- SPI slot, `sweep_en`=1, start 100, step 30, stop 200, SWEEP_DWELL=4 → `fre_k` sequence 100,130,160,190,100 every 4 cycles. Then step=0 → holds at 100. Then start=300 > stop → holds at 300.
- `rst` asserted mid-sweep → all outputs at reset values asynchronously; after release `fre_k`=102900 with no spurious press.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the TX control path: preset FSM states and default timing constants.
package tx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FIXED = 2'd0,
        ST_TRACK = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam int DEF_BASE_FREQ = 34300;
    localparam int DEF_DB_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level counter, one-cycle pulse on accepted press.
module key_debounce
    import tx_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic kin_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            press_d = ~sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], kin_n};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/preset_wave_ctrl.sv
// Front-panel preset controller: key-driven preset table with SPI-tracking slot, linear sweep and
// waveform override, producing the DDS frequency word and one-hot-low wave select.
module preset_wave_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int NUM_PRESET  = 4,
    parameter int FW          = 32,
    parameter int NUM_WAVE    = 3,
    parameter int BASE_FREQ   = DEF_BASE_FREQ,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int SWEEP_DWELL = 50000,
    localparam int WW         = $clog2(NUM_WAVE),
    localparam int PW         = $clog2(NUM_PRESET)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_mode_n,
    input  logic                key_wave_n,
    input  logic [FW-1:0]       spi_fre,
    input  logic [WW-1:0]       spi_wave,
    input  logic                sweep_en,
    input  logic [FW-1:0]       sweep_stop,
    input  logic [FW-1:0]       sweep_step,
    output logic [FW-1:0]       fre_k,
    output logic [NUM_WAVE-1:0] sel_wave,
    output logic [PW-1:0]       preset_idx,
    output logic                sweeping,
    output logic                fre_valid
);

    localparam int LAST = NUM_PRESET - 1;
    localparam int DW   = (SWEEP_DWELL > 1) ? $clog2(SWEEP_DWELL) : 1;

    function automatic logic [FW-1:0] fixed_freq(input logic [PW-1:0] idx);
        logic [63:0] p;
        p = 64'(BASE_FREQ) * (64'(idx) + 64'd3);
        return p[FW-1:0];
    endfunction

    function automatic logic [WW-1:0] ofs_inc(input logic [WW-1:0] ofs);
        return WW'((int'(ofs) + 1) % NUM_WAVE);
    endfunction

    logic mode_press, wave_press;
    logic mode_level, wave_level;
    logic unused_levels;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .kin_n (key_mode_n),
        .level (mode_level),
        .press (mode_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_wave (
        .clk   (clk),
        .rst   (rst),
        .kin_n (key_wave_n),
        .level (wave_level),
        .press (wave_press)
    );

    assign unused_levels = mode_level ^ wave_level;

    logic [PW-1:0]       idx_q, idx_d;
    logic [WW-1:0]       ofs_q, ofs_d;
    state_t              state_q, state_d;
    logic [FW-1:0]       acc_q, acc_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [FW-1:0]       fre_q, fre_d;
    logic [NUM_WAVE-1:0] sel_q, sel_d;
    logic                valid_q, valid_d;
    logic [FW:0]         next_sum;
    int                  base_w, eff_w;

    // Key handling: a mode press restarts the override, a coincident wave press then counts once.
    always_comb begin
        idx_d = idx_q;
        ofs_d = ofs_q;
        if (mode_press) begin
            idx_d = (idx_q == PW'(LAST)) ? '0 : idx_q + 1'b1;
            ofs_d = wave_press ? ofs_inc('0) : '0;
        end else if (wave_press) begin
            ofs_d = ofs_inc(ofs_q);
        end
    end

    always_comb begin
        state_d = ST_FIXED;
        if (idx_q == PW'(LAST)) begin
            state_d = sweep_en ? ST_SWEEP : ST_TRACK;
        end
    end

    // Sweep accumulator; the entry cycle reloads the start so an aborted sweep never resumes.
    always_comb begin
        acc_d    = acc_q;
        dwell_d  = dwell_q;
        next_sum = {1'b0, acc_q} + {1'b0, sweep_step};
        if (state_d == ST_SWEEP) begin
            if (state_q != ST_SWEEP) begin
                acc_d   = spi_fre;
                dwell_d = '0;
            end else if (dwell_q == DW'(SWEEP_DWELL - 1)) begin
                dwell_d = '0;
                if (sweep_step == '0 || spi_fre > sweep_stop ||
                    next_sum[FW] || next_sum[FW-1:0] > sweep_stop) begin
                    acc_d = spi_fre;
                end else begin
                    acc_d = next_sum[FW-1:0];
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_comb begin
        fre_d  = fixed_freq(idx_q);
        base_w = int'(idx_q) % NUM_WAVE;
        case (state_d)
            ST_TRACK: fre_d = spi_fre;
            ST_SWEEP: fre_d = acc_d;
            default:  fre_d = fixed_freq(idx_q);
        endcase
        if (state_d != ST_FIXED) begin
            base_w = (int'(spi_wave) >= NUM_WAVE) ? 0 : int'(spi_wave);
        end
        eff_w = (base_w + int'(ofs_q)) % NUM_WAVE;
        sel_d = '1;
        for (int k = 0; k < NUM_WAVE; k++) begin
            sel_d[k] = (k != eff_w);
        end
        valid_d = (fre_d != fre_q) || (sel_d != sel_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            ofs_q   <= '0;
            state_q <= ST_FIXED;
            acc_q   <= '0;
            dwell_q <= '0;
            fre_q   <= fixed_freq('0);
            sel_q   <= {{(NUM_WAVE-1){1'b1}}, 1'b0};
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            ofs_q   <= ofs_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            dwell_q <= dwell_d;
            fre_q   <= fre_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign fre_k      = fre_q;
    assign sel_wave   = sel_q;
    assign preset_idx = idx_q;
    assign sweeping   = (state_q == ST_SWEEP);
    assign fre_valid  = valid_q;

endmodule

// File: tb/tb_preset_wave_ctrl.sv
// Directed bench for preset_wave_ctrl: reset, debounce, preset wrap, SPI tracking, wave override,
// sweep sequencing and asynchronous reset mid-sweep.
module tb_preset_wave_ctrl;

    localparam int FW  = 32;
    localparam int DB  = 16;
    localparam int DWL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_mode_n, key_wave_n;
    logic [FW-1:0] spi_fre, sweep_stop, sweep_step;
    logic [1:0]    spi_wave;
    logic          sweep_en;
    logic [FW-1:0] fre_k;
    logic [2:0]    sel_wave;
    logic [1:0]    preset_idx;
    logic          sweeping, fre_valid;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    logic [FW-1:0] exp_q[$];

    preset_wave_ctrl #(
        .NUM_PRESET  (4),
        .FW          (FW),
        .NUM_WAVE    (3),
        .BASE_FREQ   (34300),
        .DB_CYCLES   (DB),
        .SWEEP_DWELL (DWL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_mode_n (key_mode_n),
        .key_wave_n (key_wave_n),
        .spi_fre    (spi_fre),
        .spi_wave   (spi_wave),
        .sweep_en   (sweep_en),
        .sweep_stop (sweep_stop),
        .sweep_step (sweep_step),
        .fre_k      (fre_k),
        .sel_wave   (sel_wave),
        .preset_idx (preset_idx),
        .sweeping   (sweeping),
        .fre_valid  (fre_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fre_valid) vcnt <= vcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic w);
        key_mode_n = ~m;
        key_wave_n = ~w;
        tick(DB + 8);
        key_mode_n = 1'b1;
        key_wave_n = 1'b1;
        tick(DB + 8);
    endtask

    initial begin
        int v0;
        logic found;
        logic [FW-1:0] cap_fre;
        logic [2:0] cap_sel;
        logic [1:0] cap_idx;
        logic [FW-1:0] prev;

        rst        = 1'b1;
        key_mode_n = 1'b1;
        key_wave_n = 1'b1;
        spi_fre    = 5000;
        spi_wave   = 2;
        sweep_en   = 1'b0;
        sweep_stop = 200;
        sweep_step = 30;
        tick(3);
        check("rst_fre", fre_k, 102900);
        check("rst_sel", sel_wave, 3'b110);
        check("rst_idx", preset_idx, 0);
        check("rst_valid", fre_valid, 0);
        check("rst_sweeping", sweeping, 0);
        rst = 1'b0;
        tick(4);

        // Bounce the mode key faster than the debounce window, then hold it low.
        v0 = vcnt;
        for (int i = 0; i < 10; i++) begin
            key_mode_n = ~key_mode_n;
            tick(5);
        end
        key_mode_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (fre_valid) begin
                found   = 1'b1;
                cap_fre = fre_k;
                cap_sel = sel_wave;
                cap_idx = preset_idx;
            end
        end
        check("bounce_seen", found, 1);
        if (found) begin
            check("bounce_idx", cap_idx, 1);
            check("bounce_fre", cap_fre, 137200);
            check("bounce_sel", cap_sel, 3'b101);
        end
        tick(1);
        key_mode_n = 1'b1;
        tick(DB + 8);
        check("bounce_one_press", vcnt - v0, 1);

        press(1'b1, 1'b0);
        check("idx2", preset_idx, 2);
        check("idx2_fre", fre_k, 171500);
        check("idx2_sel", sel_wave, 3'b011);
        press(1'b1, 1'b0);
        check("idx3", preset_idx, 3);
        check("track_fre", fre_k, 5000);
        check("track_sel", sel_wave, 3'b011);
        check("track_sweeping", sweeping, 0);
        spi_fre = 6000;
        @(negedge clk);
        check("track_before_edge", fre_k, 5000);
        @(negedge clk);
        check("track_one_cycle", fre_k, 6000);
        spi_wave = 3;
        tick(2);
        check("track_bad_wave", sel_wave, 3'b110);
        press(1'b1, 1'b0);
        check("wrap_idx", preset_idx, 0);
        check("wrap_fre", fre_k, 102900);

        press(1'b0, 1'b1);
        check("wave1_sel", sel_wave, 3'b101);
        check("wave1_fre", fre_k, 102900);
        press(1'b0, 1'b1);
        check("wave2_sel", sel_wave, 3'b011);
        press(1'b1, 1'b1);
        check("simul_idx", preset_idx, 1);
        check("simul_sel", sel_wave, 3'b011);
        check("simul_fre", fre_k, 137200);

        spi_fre = 100;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pre_sweep_fre", fre_k, 100);
        check("pre_sweep_sel", sel_wave, 3'b110);
        sweep_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("sweep_entry_fre", fre_k, 100);
        check("sweep_entry_flag", sweeping, 1);
        exp_q.push_back(130);
        exp_q.push_back(160);
        exp_q.push_back(190);
        exp_q.push_back(100);
        prev = 100;
        while (exp_q.size() > 0) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("sweep_dwell_hold", fre_k, prev);
            @(posedge clk);
            @(negedge clk);
            prev = exp_q.pop_front();
            check("sweep_step", fre_k, prev);
        end
        sweep_step = 0;
        tick(3 * DWL);
        check("sweep_step0_hold", fre_k, 100);
        spi_fre = 300;
        tick(3 * DWL);
        check("sweep_start_gt_stop", fre_k, 300);
        check("sweep_still_flag", sweeping, 1);

        spi_fre    = 100;
        sweep_step = 30;
        tick(2 * DWL + 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_fre", fre_k, 102900);
        check("async_rst_sel", sel_wave, 3'b110);
        check("async_rst_idx", preset_idx, 0);
        check("async_rst_sweeping", sweeping, 0);
        check("async_rst_valid", fre_valid, 0);
        tick(2);
        rst = 1'b0;
        v0 = vcnt;
        tick(DB + 20);
        check("post_rst_no_press", vcnt - v0, 0);
        check("post_rst_idx", preset_idx, 0);
        check("post_rst_fre", fre_k, 102900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
